// File: rtl/bram_ctrl_pkg.sv
// Shared defaults, controller state encoding and read-latency limits for bram_ctrl.
package bram_ctrl_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 16;
   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } ctrl_state_e;

   function automatic bit rd_lat_legal(input int lat);
      return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
   endfunction

endpackage

// File: rtl/bram_ctrl_rsp_fifo.sv
// In-order read-response FIFO with registered occupancy count.
module bram_ctrl_rsp_fifo
   import bram_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 4,
   parameter int CW     = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [CW-1:0]     count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_C = PW'(DEPTH - 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              do_push;
   logic              do_pop;

   always_comb begin
      do_push  = push && (count_q != FULL_C);
      do_pop   = pop && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible while counted.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign valid = (count_q != '0);
   assign data  = valid ? mem_q[rd_ptr_q] : '0;
   assign count = count_q;

endmodule

// File: rtl/bram_ctrl.sv
// BRAM port-A controller: combinational request path, read-latency tracking and in-order responses.
// Define BRAM_CTRL_CLEAR_EN to zero the whole BRAM after every reset before accepting requests.
//
// state | meaning
// CLEAR | sequencer writes 0 to each address in ascending order, requests held off
// IDLE  | normal operation, requests accepted while response credit remains
module bram_ctrl
   import bram_ctrl_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int RD_LAT    = 1,
   parameter int RSP_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              bram_en,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_din,
   input  logic [DATA_W-1:0] bram_dout,
   output logic              init_done
);

   localparam int LAT = rd_lat_legal(RD_LAT) ? RD_LAT : RD_LAT_MIN;
   localparam int CW  = $clog2(RSP_DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(RSP_DEPTH);

   logic           run_q, run_d;
   logic [LAT-1:0] rd_vld_q, rd_vld_d;
   logic [CW-1:0]  fifo_count;
   logic [CW:0]    inflight;
   logic [CW:0]    credit_used;
   logic           init_done_w;
   logic           acc;
   logic           push;
   logic           pop;

`ifdef BRAM_CTRL_CLEAR_EN
   ctrl_state_e       state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      case (state_q)
         CLEAR: begin
            if (run_q) begin
               clr_addr_d = clr_addr_q + ADDR_W'(1);
               if (&clr_addr_q) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   assign init_done_w = (state_q == IDLE);
`else
   assign init_done_w = 1'b1;
`endif

   // run_q holds everything quiet until the first edge after reset release.
   assign run_d = 1'b1;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LAT; i++) begin
         inflight = inflight + {{CW{1'b0}}, rd_vld_q[i]};
      end
      credit_used = inflight + {1'b0, fifo_count};
      req_ready   = init_done_w & run_q & (credit_used < DEPTH_C);
   end

   always_comb begin
      acc       = req_valid & req_ready;
      bram_en   = acc;
      bram_we   = acc & req_we;
      bram_addr = run_q ? req_addr : '0;
      bram_din  = run_q ? req_wdata : '0;
`ifdef BRAM_CTRL_CLEAR_EN
      if (state_q == CLEAR) begin
         bram_en   = run_q;
         bram_we   = run_q;
         bram_addr = clr_addr_q;
         bram_din  = '0;
      end
`endif
   end

   always_comb begin
      rd_vld_d    = '0;
      rd_vld_d[0] = acc & ~req_we;
      for (int i = 1; i < LAT; i++) begin
         rd_vld_d[i] = rd_vld_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q    <= 1'b0;
         rd_vld_q <= '0;
      end else begin
         run_q    <= run_d;
         rd_vld_q <= rd_vld_d;
      end
   end

   assign push      = rd_vld_q[LAT-1];
   assign pop       = rsp_valid & rsp_ready;
   assign init_done = init_done_w;

   bram_ctrl_rsp_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (RSP_DEPTH),
      .CW     (CW)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (bram_dout),
      .pop       (pop),
      .valid     (rsp_valid),
      .data      (rsp_data),
      .count     (fifo_count)
   );

endmodule

// File: doc/bram_ctrl.md
BRAM_CTRL -- requirements
Module: bram_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W  4  BRAM address width (16 words)
  DATA_W  16  BRAM data width
  RD_LAT  1  BRAM read latency in cycles; legal values 1 or 2
  RSP_DEPTH  4  read-response FIFO depth; must be at least RD_LAT+1
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all logic on its rising edge
  rst  in  1  asynchronous, active-high reset
  req_valid  in  1  request present
  req_ready  out  1  request accepted on the edge where valid&ready=1
  req_we  in  1  1=write, 0=read
  req_addr  in  ADDR_W  request address
  req_wdata  in  DATA_W  write data
  rsp_valid  out  1  read data available
  rsp_ready  in  1  consumer takes rsp_data
  rsp_data  out  DATA_W  read data, in request order
  bram_en  out  1  BRAM port-A enable (ena)
  bram_we  out  1  BRAM port-A write enable (wea)
  bram_addr  out  ADDR_W  BRAM addra
  bram_din  out  DATA_W  BRAM dina
  bram_dout  in  DATA_W  BRAM douta
  init_done  out  1  controller accepting requests

Function
REQ-003 The BRAM outputs SHALL be combinational from the request: bram_en=req_valid&req_ready, bram_we=bram_en&req_we, bram_addr=req_addr, bram_din=req_wdata; in CLEAR state the clear sequencer drives them instead.
REQ-004 req_ready SHALL equal init_done & (inflight+fifo_count < RSP_DEPTH), and SHALL NOT depend on req_valid.
REQ-005 An accepted read SHALL enter an RD_LAT-stage valid shift register; bram_dout SHALL be pushed into the response FIFO on the edge RD_LAT cycles after the accepting edge.
REQ-006 With an empty FIFO, rsp_valid SHALL assert in the cycle after edge RD_LAT+1 following acceptance.
REQ-007 Write latency SHALL be zero extra cycles: a write issued on edge N is readable by a read accepted on edge N+1.
REQ-008 rsp_valid SHALL equal fifo non-empty; a pop SHALL occur on rsp_valid&rsp_ready; simultaneous push and pop SHALL leave the count unchanged.
REQ-009 The credit rule in REQ-004 SHALL make FIFO overflow impossible; push-when-full SHALL never occur.
REQ-010 Read data SHALL be returned strictly in acceptance order; writes SHALL produce no response.

Reset
REQ-011 On rst: bram_en=0, bram_we=0, bram_addr=0, bram_din=0, rsp_valid=0, rsp_data=0, req_ready=0, FIFO flushed, inflight=0; init_done=0 if clear is compiled in, else 1.
REQ-012 Reset asserted mid-operation SHALL discard every in-flight read and queued response; no rsp_valid SHALL follow for those reads.

Configuration
REQ-013 Macro BRAM_CTRL_CLEAR_EN: when defined, after reset release an FSM in state CLEAR SHALL write 0 to addresses 0..2^ADDR_W-1, one per cycle, ascending (16 cycles). It SHALL then enter IDLE and set init_done=1. req_ready SHALL stay 0 during CLEAR.
REQ-014 Without BRAM_CTRL_CLEAR_EN, the FSM SHALL start in IDLE and init_done SHALL be constant 1 after reset; BRAM contents SHALL be left untouched.

Structure
REQ-015 A shared package bram_ctrl_pkg SHALL hold the ADDR_W/DATA_W defaults, the FSM state enum {CLEAR, IDLE}, and the RD_LAT legality constants.
REQ-016 The response FIFO SHALL be a sub-module bram_ctrl_rsp_fifo (synchronous, registered count, same clk/rst).

Verification
REQ-017 Write addr 0..15 with data 0x1000+i, then read 0..15 with rsp_ready=1 -> rsp_data 0x1000..0x100F in order, each RD_LAT+1 edges after its acceptance.
REQ-018 Hold rsp_ready=0 and issue 6 back-to-back reads -> req_ready drops after RSP_DEPTH=4 acceptances. Releasing rsp_ready -> all 4 returned, then the remaining 2 accepted, with no loss or duplication.
REQ-019 Write 0xBEEF to addr 5 on edge N and read addr 5 on edge N+1 -> rsp_data=0xBEEF.
REQ-020 Assert rst with 2 reads in flight and 2 queued -> rsp_valid=0 immediately and no responses after release.
REQ-021 With BRAM_CTRL_CLEAR_EN, preload BRAM with nonzero data and reset -> 16 zero writes at addr 0..15, then init_done=1, and all reads return 0x0000. Without the macro, init_done=1 on the first edge and the preload data reads back.
REQ-022 Run with RD_LAT=2 and RSP_DEPTH=4 -> REQ-017 passes with 3-edge latency.
